// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two request ports and one tagged response port of the shared ALU
interface alu_arbiter_if #(parameter int DATA_W = 32, parameter int ID_W = 1);
  logic              req0_valid, req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
  );
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters into a tagged result slot.
// Defining ALU_ARB_STATS_EN adds saturating per-requester accept counters grant_cnt0/grant_cnt1.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 1
) (
  input logic clk,
  input logic reset,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic last_grant, grant, can_accept, ready0, ready1, accept;
  logic [2:0] op;
  logic [DATA_W-1:0] a, b, result;
  function automatic logic [DATA_W-1:0] alu(input logic [2:0] f, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    return f == 3'b000 ? x + y :
           f == 3'b001 ? x - y :
           f == 3'b010 ? x | y :
           f == 3'b011 ? DATA_W'({y[15:0], x[15:0]}) :
           f == 3'b100 ? (y >= DATA_W'(DATA_W) ? '0 : x << y) : '0;
  endfunction
  always_comb begin
    grant = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    can_accept = (state == EMPTY) | bus.rsp_ready;
    ready0 = can_accept & ~grant & bus.req0_valid;
    ready1 = can_accept & grant & bus.req1_valid;
    accept = ready0 | ready1;
    op = grant ? bus.req1_op : bus.req0_op;
    a = grant ? bus.req1_a : bus.req0_a;
    b = grant ? bus.req1_b : bus.req0_b;
    result = alu(op, a, b);
    state_nxt = (accept | ((state == FULL) & ~bus.rsp_ready)) ? FULL : EMPTY;
  end
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid = state == FULL;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      last_grant <= 1'b1;
      bus.rsp_id <= '0;
      bus.rsp_data <= '0;
      bus.rsp_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        bus.rsp_id <= ID_W'(grant);
        bus.rsp_data <= result;
        bus.rsp_zero <= (op == 3'b001) & (result == '0);
      end
    end
  end
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (ready0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (ready1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  alu_arbiter_if #(.DATA_W(32), .ID_W(1)) bus();
`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0, cnt1;
  alu_arbiter dut (.clk(clk), .reset(reset), .bus(bus), .grant_cnt0(cnt0), .grant_cnt1(cnt1));
`else
  alu_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return (32'(b[15:0]) << 16) | 32'(a[15:0]);
      3'd4: return (b > 32'd31) ? 32'd0 : a * (32'd1 << b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %0b want 0", bus.rsp_id); end
    checks++; if (bus.rsp_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.rsp_data); end
    checks++; if (bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %0b want 0", bus.rsp_zero); end
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL reset_first_grant got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();
  endtask

  task automatic test_single_add();
    do_reset();
    bus.req0_valid = 1; bus.req0_op = 3'd0; bus.req0_a = 5; bus.req0_b = 7;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %0b want 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 0;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL add_id got %0b want 0", bus.rsp_id); end
    checks++; if (bus.rsp_data !== 32'd12) begin errors++; $display("FAIL add_data got %0d want 12", bus.rsp_data); end
    checks++; if (bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL add_zero got %0b want 0", bus.rsp_zero); end
    tick();
  endtask

  task automatic test_contention();
    logic prev;
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 10; bus.req0_b = 1;
    bus.req1_valid = 1; bus.req1_a = 20; bus.req1_b = 2;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_grant%0d got %b want %b", i, {bus.req0_ready, bus.req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      if (i > 0) begin
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== prev) begin errors++; $display("FAIL contention_rsp%0d got v=%0b id=%0b want v=1 id=%0b", i, bus.rsp_valid, bus.rsp_id, prev); end
      end
      prev = (i % 2 == 1);
      tick();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== 32'd22) begin errors++; $display("FAIL contention_last got v=%0b id=%0b d=%0d want v=1 id=1 d=22", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.rsp_ready = 0;
    bus.req1_valid = 1; bus.req1_op = 3'd1; bus.req1_a = 9; bus.req1_b = 9;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %0b want 1", bus.req1_ready); end
    tick();
    bus.req1_valid = 0;
    bus.req0_valid = 1; bus.req0_op = 3'd0; bus.req0_a = 1; bus.req0_b = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd0 || bus.rsp_zero !== 1'b1 || bus.rsp_id !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got v=%0b d=%h z=%0b id=%0b want v=1 d=0 z=1 id=1", i, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_id); end
      checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b want 00", i, {bus.req0_ready, bus.req1_ready}); end
      tick();
    end
    bus.rsp_ready = 1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b want 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'd3 || bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL bp_refill got v=%0b id=%0b d=%0d z=%0b want v=1 id=0 d=3 z=0", bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero); end
    tick();
  endtask

  task automatic test_op_corners();
    logic [2:0]  ops [5] = '{3'd3, 3'd4, 3'd4, 3'd1, 3'd6};
    logic [31:0] as  [5] = '{32'h1234ABCD, 32'd1, 32'hFFFFFFFF, 32'd0, 32'hDEADBEEF};
    logic [31:0] bs  [5] = '{32'h5678EF01, 32'd31, 32'd32, 32'd1, 32'h12345678};
    logic [31:0] exp [5] = '{32'hEF01ABCD, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.req0_valid = 1; bus.req0_op = ops[i]; bus.req0_a = as[i]; bus.req0_b = bs[i];
      tick();
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp[i] || bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL op_corner%0d got v=%0b d=%h z=%0b want v=1 d=%h z=0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, exp[i]); end
    end
    bus.req0_valid = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rsp_ready = 0;
    bus.req1_valid = 1; bus.req1_op = 3'd0; bus.req1_a = 3; bus.req1_b = 4;
    tick();
    bus.req1_valid = 0;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_full got %0b want 1", bus.rsp_valid); end
    reset = 1;
    tick();
    reset = 0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'd0 || bus.rsp_id !== 1'b0) begin errors++; $display("FAIL mid_empty got v=%0b d=%h id=%0b want v=0 d=0 id=0", bus.rsp_valid, bus.rsp_data, bus.rsp_id); end
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_first_grant got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.rsp_ready = 1;
    tick();
  endtask

  task automatic new_req(output logic v, output logic [2:0] op, output logic [31:0] a, output logic [31:0] b);
    v = $urandom_range(1);
    op = 3'($urandom_range(7));
    a = ($urandom_range(3) == 0) ? 32'($urandom_range(4)) : $urandom;
    b = (op == 3'd4) ? 32'($urandom_range(40)) : ($urandom_range(3) == 0) ? a : $urandom;
  endtask

  task automatic test_random();
    logic m_full, m_last, m_id, m_zero, win, e0, e1, nv;
    logic [31:0] m_data, na, nb;
    logic [2:0] nop;
    do_reset();
    m_full = 0; m_last = 1; m_id = 0; m_zero = 0; m_data = 0;
    for (int i = 0; i < 400; i++) begin
      bus.rsp_ready = ($urandom_range(3) != 0);
      #1;
      win = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      e0 = (!m_full || bus.rsp_ready) && bus.req0_valid && !win;
      e1 = (!m_full || bus.rsp_ready) && bus.req1_valid && win;
      checks++; if ({bus.req0_ready, bus.req1_ready} !== {e0, e1}) begin errors++; $display("FAIL rand_ready cycle %0d got %b want %b", i, {bus.req0_ready, bus.req1_ready}, {e0, e1}); end
      if (e0 || e1) begin
        m_data = e1 ? ref_alu(bus.req1_op, bus.req1_a, bus.req1_b) : ref_alu(bus.req0_op, bus.req0_a, bus.req0_b);
        m_zero = ((e1 ? bus.req1_op : bus.req0_op) == 3'd1) && m_data == 0;
        m_id = e1; m_last = e1; m_full = 1;
      end else if (bus.rsp_ready) m_full = 0;
      tick();
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero} !== {m_full, m_id, m_zero} || bus.rsp_data !== m_data) begin errors++; $display("FAIL rand_rsp cycle %0d got v=%0b id=%0b z=%0b d=%h want v=%0b id=%0b z=%0b d=%h", i, bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_data, m_full, m_id, m_zero, m_data); end
      if (e0 || !bus.req0_valid) begin
        new_req(nv, nop, na, nb);
        bus.req0_valid = nv; bus.req0_op = nop; bus.req0_a = na; bus.req0_b = nb;
      end else if ($urandom_range(7) == 0) bus.req0_valid = 0;
      if (e1 || !bus.req1_valid) begin
        new_req(nv, nop, na, nb);
        bus.req1_valid = nv; bus.req1_op = nop; bus.req1_a = na; bus.req1_b = nb;
      end else if ($urandom_range(7) == 0) bus.req1_valid = 0;
    end
    idle_inputs();
    tick();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.req0_valid = 1; bus.req1_valid = 1;
    repeat (4) tick();
    bus.req1_valid = 0;
    tick();
    bus.req0_valid = 0;
    tick();
    checks++; if (cnt0 !== 16'd3 || cnt1 !== 16'd2) begin errors++; $display("FAIL stats_count got %0d/%0d want 3/2", cnt0, cnt1); end
    bus.req0_valid = 1;
    repeat (65540) tick();
    bus.req0_valid = 0;
    tick();
    checks++; if (cnt0 !== 16'hFFFF || cnt1 !== 16'd2) begin errors++; $display("FAIL stats_sat got %h/%0d want ffff/2", cnt0, cnt1); end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_op_corners();
    test_reset_mid();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
